// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared func encodings, latency constant and operand helpers for mul_unit
// Latency follows MUL_UNIT_PROD_REG_EN: 3 when defined, 2 otherwise.
package mul_pkg;

  typedef enum logic [1:0] {
    FUNC_MUL    = 2'b00,
    FUNC_MULH   = 2'b01,
    FUNC_MULHSU = 2'b10,
    FUNC_MULHU  = 2'b11
  } funcT;

`ifdef MUL_UNIT_PROD_REG_EN
  localparam int LATENCY = 3;
`else
  localparam int LATENCY = 2;
`endif

  function automatic logic rs1IsSigned(input funcT f);
    return (f == FUNC_MULH) || (f == FUNC_MULHSU);
  endfunction

  function automatic logic rs2IsSigned(input funcT f);
    return (f == FUNC_MULH);
  endfunction

  // Two's-complement negate of 0x80000000 wraps back to 0x80000000, which is the
  // correct unsigned magnitude, so no extra bit is needed.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic isSigned);
    return (isSigned && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_unit_mul32u.sv
// rtl/mul_unit_mul32u.sv - unsigned 32x32->64 multiplier core used by mul_unit
module Mul32U (
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [63:0] res
);

  assign res = {32'd0, op1} * {32'd0, op2};

endmodule

// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - pipelined RISC-V style multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready flow control
// Define MUL_UNIT_PROD_REG_EN to add the S2 product register (latency 3 instead of 2).
module mul_unit
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  func,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  funcT        inFunc;
  logic        inNeg;
  logic        accept;

  logic        s1Valid;
  funcT        s1Func;
  logic [31:0] s1Mag1;
  logic [31:0] s1Mag2;
  logic        s1Neg;
  logic        s1Advance;

  logic [63:0] coreProd;

  // Source feeding S3: either S1 + combinational product, or the S2 register.
  logic        srcValid;
  funcT        srcFunc;
  logic        srcNeg;
  logic [63:0] srcProd;

  logic        s3Valid;
  logic [31:0] s3Data;
  logic        s3Load;
  logic [63:0] resultP;
  logic [31:0] resultWord;

  assign inFunc = funcT'(func);
  assign inNeg  = (rs1IsSigned(inFunc) & rs1[31]) ^ (rs2IsSigned(inFunc) & rs2[31]);
  assign accept = in_valid && in_ready;

  // S3 takes a new entry whenever it is empty or its current result is leaving.
  assign s3Load = srcValid && (!s3Valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1Func  <= FUNC_MUL;
      s1Mag1  <= 32'd0;
      s1Mag2  <= 32'd0;
      s1Neg   <= 1'b0;
    end else begin
      if (in_ready) s1Valid <= in_valid;
      if (accept) begin
        s1Func <= inFunc;
        s1Mag1 <= magnitude(rs1, rs1IsSigned(inFunc));
        s1Mag2 <= magnitude(rs2, rs2IsSigned(inFunc));
        s1Neg  <= inNeg;
      end
    end
  end

  Mul32U uCore (
    .op1 (s1Mag1),
    .op2 (s1Mag2),
    .res (coreProd)
  );

`ifdef MUL_UNIT_PROD_REG_EN
  logic        s2Valid;
  funcT        s2Func;
  logic        s2Neg;
  logic [63:0] s2Prod;
  logic        s2Ready;

  assign s2Ready   = !s2Valid || s3Load;
  assign s1Advance = s1Valid && s2Ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid <= 1'b0;
      s2Func  <= FUNC_MUL;
      s2Neg   <= 1'b0;
      s2Prod  <= 64'd0;
    end else begin
      if (s2Ready) s2Valid <= s1Valid;
      if (s1Advance) begin
        s2Func <= s1Func;
        s2Neg  <= s1Neg;
        s2Prod <= coreProd;
      end
    end
  end

  assign srcValid = s2Valid;
  assign srcFunc  = s2Func;
  assign srcNeg   = s2Neg;
  assign srcProd  = s2Prod;
`else
  assign s1Advance = s3Load;
  assign srcValid  = s1Valid;
  assign srcFunc   = s1Func;
  assign srcNeg    = s1Neg;
  assign srcProd   = coreProd;
`endif

  assign in_ready = !s1Valid || s1Advance;

  always_comb begin
    resultP    = srcNeg ? (~srcProd + 64'd1) : srcProd;
    resultWord = (srcFunc == FUNC_MUL) ? resultP[31:0] : resultP[63:32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3Valid <= 1'b0;
      s3Data  <= 32'd0;
    end else begin
      if (!s3Valid || out_ready) s3Valid <= srcValid;
      if (s3Load) s3Data <= resultWord;
    end
  end

  assign out_valid = s3Valid;
  assign out_data  = s3Data;

endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - self-checking bench for mul_unit against an arithmetic reference model
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  func = 2'b00;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  int testsRun = 0;
  int testsFailed = 0;
  int expLat;
  int cycleNo = 0;
  int delivered = 0;
  logic [31:0] expQ[$];
  int delivCycles[$];

  always #5 clk = ~clk;

  mul_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full-precision signed arithmetic on sign- or zero-extended operands.
  function automatic logic [31:0] refModel(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] x, y, p;
    x = (f == 2'b01 || f == 2'b10) ? {{34{a[31]}}, a} : {34'd0, a};
    y = (f == 2'b01) ? {{34{b[31]}}, b} : {34'd0, b};
    p = x * y;
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic randomReq();
    func = 2'($urandom_range(0, 3));
    rs1  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    rs2  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
  endtask

  // One clock: record accepts/deliveries before the edge, check hold after it.
  task automatic tick();
    logic pv, pr;
    logic [31:0] pd;
    if (in_valid && in_ready) expQ.push_back(refModel(func, rs1, rs2));
    if (out_valid && out_ready) begin
      check("result_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) check("result_data", out_data, expQ.pop_front());
      delivered++;
      delivCycles.push_back(cycleNo);
    end
    pv = out_valid;
    pr = out_ready;
    pd = out_data;
    @(posedge clk);
    #1;
    cycleNo++;
    if (pv && !pr) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, pd);
    end
  endtask

  // Latency counts edges starting with the accepting edge.
  task automatic single(input string tag, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    func = f;
    rs1  = a;
    rs2  = b;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(expLat));
    check({tag, "_data"}, out_data, exp);
    @(posedge clk);
    #1;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [1:0]  bpFunc[4];
    logic [31:0] bpA[4];
    logic [31:0] bpB[4];
    int issued;
    bit sawStall;
    bit acc;
`ifdef MUL_UNIT_PROD_REG_EN
    expLat = 3;
`else
    expLat = 2;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed values and sign modes
    single("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000_002A);
    single("mul_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
    single("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    single("mulhsu_ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    single("mulhu_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    single("mulh_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);

    // Back-to-back random requests
    out_ready = 1'b1;
    delivered = 0;
    delivCycles.delete();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      randomReq();
      #1;
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) tick();
    check("b2b_count", 32'(delivered), 32'd8);
    check("b2b_queue_empty", 32'(expQ.size()), 32'd0);
    if (delivCycles.size() == 8)
      check("b2b_consecutive", 32'(delivCycles[7] - delivCycles[0]), 32'd7);

    // Backpressure: out_ready low for 6 cycles while 4 requests are offered
    for (int i = 0; i < 4; i++) begin
      bpFunc[i] = 2'($urandom_range(0, 3));
      bpA[i] = $urandom;
      bpB[i] = $urandom;
    end
    delivered = 0;
    issued = 0;
    sawStall = 1'b0;
    for (int cyc = 0; cyc < 40 && (issued < 4 || expQ.size() != 0); cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (issued < 4);
      if (issued < 4) begin
        func = bpFunc[issued];
        rs1  = bpA[issued];
        rs2  = bpB[issued];
      end
      #1;
      if (in_valid && !in_ready) sawStall = 1'b1;
      acc = in_valid && in_ready;
      tick();
      if (acc) issued++;
    end
    in_valid = 1'b0;
    check("bp_stall_seen", 32'(sawStall), 32'd1);
    check("bp_issued", 32'(issued), 32'd4);
    check("bp_delivered", 32'(delivered), 32'd4);
    check("bp_queue_empty", 32'(expQ.size()), 32'd0);

    // Reset with two requests in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      randomReq();
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    single("post_rst_mul", 2'b00, 32'd12345, 32'd678, 32'd8369910);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: request present.
REQ-004 SHALL have port in_ready, output, 1 bit: unit can accept a request this cycle.
REQ-005 SHALL have port func, input, 2 bits: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 SHALL have port rs1, input, 32 bits: multiplicand.
REQ-007 SHALL have port rs2, input, 32 bits: multiplier.
REQ-008 SHALL have port out_valid, output, 1 bit: result present.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port out_data, output, 32 bits: selected result word.

Function
REQ-011 SHALL accept a request on a rising edge where in_valid and in_ready are both 1; SHALL deliver a result on an edge where out_valid and out_ready are both 1.
REQ-012 Stage S1 SHALL register func, |rs1| and |rs2| as 32-bit unsigned magnitudes, plus a negate flag.
- rs1 is treated as signed for MULH and MULHSU; rs2 is treated as signed for MULH only; all other operands are unsigned.
- negate = XOR of the sign bits of the operands treated as signed.
REQ-013 The S1 magnitudes SHALL feed one unsigned 32x32->64 multiplier core. |0x80000000| = 0x80000000 with no overflow.
REQ-014 Stage S3 SHALL form P = negate ? (~prod + 1) mod 2^64 : prod.
- out_data = P[31:0] for MUL.
- out_data = P[63:32] for MULH, MULHSU and MULHU.
REQ-015 Latency SHALL be fixed: out_valid rises N edges after the accepting edge.
- N = 2 when the macro is undefined.
- N = 3 when the macro is defined.
REQ-016 Each stage SHALL advance when its successor is empty or its successor is advancing in the same cycle.
- in_ready = !S1_valid || S1_advance.
- Sustained throughput is one result per cycle when out_ready is held at 1.
REQ-017 When out_valid=1 and out_ready=0, out_data and every stage SHALL hold, in_ready SHALL fall once all stages are full, and no request SHALL be lost, duplicated or reordered.
REQ-018 When an accept and a delivery occur in the same cycle, both SHALL take effect on that edge.
REQ-019 out_data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-020 While rst=1, all stage-valid flags, out_valid and out_data SHALL be 0; in_ready SHALL be 1 in the first cycle after rst falls.
REQ-021 Asserting rst mid-operation SHALL discard every in-flight request; no result for a discarded request SHALL appear after reset.

Configuration
REQ-022 Macro MUL_UNIT_PROD_REG_EN SHALL control an S2 register on the 64-bit product.
- Defined: S2 register present, N=3, multiplier path isolated from the negate/select logic.
- Undefined: S2 absent, product feeds S3 combinationally, N=2.
- All other behaviour SHALL be identical in both builds.

Structure
REQ-023 Shared package mul_pkg SHALL hold the func encodings (FUNC_MUL, FUNC_MULH, FUNC_MULHSU, FUNC_MULHU) and the latency constant computed from the macro.
REQ-024 The unsigned 32x32 multiplier core SHALL be instantiated as the one sub-module, Mul32U (ports op1, op2, res); mul_unit SHALL contain all pipeline, sign and handshake logic.

Verification
REQ-025 MUL 7 x 6, out_ready=1 -> out_data 0x0000002A exactly N edges after accept; MUL 0xFFFFFFFD x 5 -> 0xFFFFFFF1.
REQ-026 Sign modes:
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
REQ-027 Back-to-back: 8 random requests on consecutive cycles with out_ready=1 -> 8 consecutive results, in order, matching the reference model.
REQ-028 Backpressure: hold out_ready=0 for 6 cycles while issuing 4 requests -> in_ready falls once full, out_data holds, all 4 results arrive in order after release.
REQ-029 Assert rst for 1 cycle with 2 requests in flight -> out_valid=0, out_data=0, no stale result afterwards, and the next request completes correctly.
REQ-030 Run every scenario in both builds (MUL_UNIT_PROD_REG_EN defined and undefined) -> identical results, with latency 3 and 2 respectively.
